mem_copy_engine: RTL

Word-granular copy initiator that sits on the requester side of the data-memory port. It drives Address, WriteData, MemWrite and MemRead, and samples Data. On a start pulse it copies `len` consecutive 32-bit words from `src` to `dst`, using one read cycle and one write cycle per word. It gives the system a block-move or initialisation path into data memory without routing through the pipeline.

---
 rtl/mem_copy_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// Word-granular memory copy initiator: one READ and one WRITE cycle per word, ascending order.
// Optional running checksum output `sum` is built when MEMCOPY_SUM_EN is defined.
module mem_copy_engine #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [31:0]      Address,
   output logic [31:0]      WriteData,
   output logic             MemWrite,
   output logic             MemRead,
   input  logic [31:0]      Data
`ifdef MEMCOPY_SUM_EN
   ,
   output logic [31:0]      sum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_i;
   logic [31:0]      r_buf;
   logic [LEN_W-1:0] w_i_inc;
   logic [31:0]      w_i_ext;
   logic             w_accept;

   assign w_i_inc  = r_i + ONE;
   assign w_i_ext  = 32'(r_i);
   assign w_accept = (r_state == S_IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_READ;
         S_READ:  w_next = S_WRITE;
         S_WRITE: w_next = (w_i_inc == r_len) ? S_DONE : S_READ;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Copy parameters are frozen at acceptance so later input changes cannot disturb a copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src <= '0;
         r_dst <= '0;
         r_len <= '0;
         r_i   <= '0;
         r_buf <= '0;
      end else begin
         if (w_accept) begin
            r_src <= src;
            r_dst <= dst;
            r_len <= len;
            r_i   <= '0;
         end
         if (r_state == S_READ) begin
            r_buf <= Data;
         end
         if (r_state == S_WRITE) begin
            r_i <= w_i_inc;
         end
      end
   end

`ifdef MEMCOPY_SUM_EN
   logic [31:0] r_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
      end else if (w_accept) begin
         r_sum <= '0;
      end else if (r_state == S_READ) begin
         r_sum <= r_sum + Data;
      end
   end

   assign sum = r_sum;
`endif

   // Memory-side outputs decode from registered state only; idle cycles drive all zeros.
   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_DONE);
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      unique case (r_state)
         S_READ: begin
            MemRead = 1'b1;
            Address = r_src + w_i_ext;
         end
         S_WRITE: begin
            MemWrite  = 1'b1;
            Address   = r_dst + w_i_ext;
            WriteData = r_buf;
         end
         default: ;
      endcase
   end

endmodule
